// File: rtl/alu_pkg.sv
// Shared instruction layout, opcode and shift-control encodings for the ALU issue stage.
package alu_pkg;

  localparam int REG_W = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_MOV = 4'd4,
    OP_XOR = 4'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    SR_LSL = 3'd0,
    SR_LSR = 3'd1,
    SR_ASR = 3'd2,
    SR_ROR = 3'd3,
    SR_RRX = 3'd4
  } sr_cont_e;

  // Field order fixes the bit positions of the 32-bit instruction word, msb first.
  typedef struct packed {
    logic [3:0]       opcode;
    logic [REG_W-1:0] rd;
    logic             s;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [2:0]       sr_cont;
    logic [4:0]       sr_bit;
    logic             i;
    logic [5:0]       imm_lo;
  } instr_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Per-register pending flags and issue hazard detection for alu_issue.
// Writeback-to-source bypass is enabled by defining ALU_ISSUE_FWD_EN.
import alu_pkg::*;

module alu_scoreboard #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] rm,
  input  logic [REG_W-1:0] rd,
  input  logic             use_rm,
  input  logic             issue,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_addr,
  output logic             hazard,
  output logic             fwd_rn,
  output logic             fwd_rm
);

  logic [NREGS-1:0] pending;

  // The set is written last so an issue wins over a same-cycle writeback to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (wb_en) pending[wb_addr] <= 1'b0;
      if (issue) pending[rd] <= 1'b1;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  assign fwd_rn = wb_en && (wb_addr == rn);
  assign fwd_rm = wb_en && (wb_addr == rm);
`else
  assign fwd_rn = 1'b0;
  assign fwd_rm = 1'b0;
`endif

  assign hazard = (pending[rn] && !fwd_rn) ||
                  pending[rd] ||
                  (use_rm && pending[rm] && !fwd_rm);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes, reads operands, tracks hazards and registers the issue bundle.
// Define ALU_ISSUE_FWD_EN to bypass writeback data into the source operands.
import alu_pkg::*;

module alu_issue #(
  parameter int NREGS = 16,
  parameter int IMM_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  output logic [3:0]  alu_rd,
  output logic        alu_set_flags,
  output logic        illegal_instr
);

  instr_t            dec;
  logic [31:0]       regfile [NREGS];
  logic              hazard;
  logic              fwd_rn;
  logic              fwd_rm;
  logic              accept;
  logic              issue;
  logic [IMM_W-1:0]  imm;
  logic [31:0]       src1;
  logic [31:0]       src2;

  assign dec = instr;

  alu_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .rn      (dec.rn),
    .rm      (dec.rm),
    .rd      (dec.rd),
    .use_rm  (!dec.i),
    .issue   (issue),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .hazard  (hazard),
    .fwd_rn  (fwd_rn),
    .fwd_rm  (fwd_rm)
  );

  // Gated by rst_n so nothing is offered upstream while the stage is held in reset.
  assign instr_ready = rst_n && !hazard && (!alu_valid || alu_ready);
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && is_legal(dec.opcode);

  assign imm  = IMM_W'({dec.rm, dec.imm_lo});
  assign src1 = fwd_rn ? wb_data : regfile[dec.rn];
  assign src2 = dec.i ? 32'(imm) : (fwd_rm ? wb_data : regfile[dec.rm]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
    end else if (wb_en) begin
      regfile[wb_addr] <= wb_data;
    end
  end

  // Illegal opcodes are consumed without touching the bundle; a drain still clears alu_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid     <= 1'b0;
      illegal_instr <= 1'b0;
      alu_in1       <= '0;
      alu_in2       <= '0;
      alu_opcode    <= '0;
      alu_sr_cont   <= '0;
      alu_sr_bit    <= '0;
      alu_rd        <= '0;
      alu_set_flags <= 1'b0;
    end else begin
      illegal_instr <= accept && !is_legal(dec.opcode);
      if (issue) begin
        alu_valid     <= 1'b1;
        alu_in1       <= src1;
        alu_in2       <= src2;
        alu_opcode    <= dec.opcode;
        alu_sr_cont   <= dec.sr_cont;
        alu_sr_bit    <= dec.sr_bit;
        alu_rd        <= dec.rd;
        alu_set_flags <= dec.s;
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed, table-driven bench for alu_issue with hand-written multi-cycle sequences.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b1;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_sr_cont;
  logic [4:0]  alu_sr_bit;
  logic [3:0]  alu_rd;
  logic        alu_set_flags;
  logic        illegal_instr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [2:0]  sc;
    logic [4:0]  sa;
    logic        i;
    logic [5:0]  imm;
    logic [31:0] exp_in1;
    logic [31:0] exp_in2;
  } vec_t;

  vec_t vecs [6];

  alu_issue #(.NREGS(16), .IMM_W(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_opcode    (alu_opcode),
    .alu_sr_cont   (alu_sr_cont),
    .alu_sr_bit    (alu_sr_bit),
    .alu_rd        (alu_rd),
    .alu_set_flags (alu_set_flags),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic s,
                                     input logic [3:0] rn, input logic [3:0] rm, input logic [2:0] sc,
                                     input logic [4:0] sa, input logic i, input logic [5:0] imm);
    return {op, rd, s, rn, rm, sc, sa, i, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] word, input logic valid);
    instr       = word;
    instr_valid = valid;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic wb_write(input logic [3:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    int waited;
    int exp_wait;

    vecs[0] = '{4'd1, 4'd8,  1'b1, 4'd5, 4'd1, 3'd0, 5'd0,  1'b0, 6'h00, 32'd100,       32'd5};
    vecs[1] = '{4'd2, 4'd9,  1'b0, 4'd6, 4'd7, 3'd2, 5'd31, 1'b0, 6'h00, 32'hF0F0_0000, 32'd3};
    vecs[2] = '{4'd3, 4'd10, 1'b0, 4'd1, 4'hA, 3'd1, 5'd4,  1'b1, 6'h3F, 32'd5,         32'h0000_02BF};
    vecs[3] = '{4'd5, 4'd11, 1'b1, 4'd2, 4'd0, 3'd3, 5'd1,  1'b1, 6'h00, 32'd7,         32'h0000_0000};
    vecs[4] = '{4'd4, 4'd12, 1'b0, 4'd7, 4'hF, 3'd4, 5'd17, 1'b1, 6'h01, 32'd3,         32'h0000_03C1};
    vecs[5] = '{4'd0, 4'd13, 1'b0, 4'd0, 4'd6, 3'd0, 5'd2,  1'b0, 6'h2A, 32'd0,         32'hF0F0_0000};

`ifdef ALU_ISSUE_FWD_EN
    exp_wait = 0;
`else
    exp_wait = 1;
`endif

    #2;
    check_output("reset_ready", 32'(instr_ready), 32'd0);
    check_output("reset_valid", 32'(alu_valid), 32'd0);
    check_output("reset_in1", alu_in1, 32'd0);
    check_output("reset_illegal", 32'(illegal_instr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wb_write(4'd1, 32'd5);
    wb_write(4'd2, 32'd7);
    wb_write(4'd5, 32'd100);
    wb_write(4'd6, 32'hF0F0_0000);
    wb_write(4'd7, 32'd3);

    // Basic register-register ADD r3,r1,r2 with one-cycle issue latency.
    apply_stimulus(mk(4'd0, 4'd3, 1'b0, 4'd1, 4'd2, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("add_ready", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus('0, 1'b0);
    check_output("add_valid", 32'(alu_valid), 32'd1);
    check_output("add_in1", alu_in1, 32'd5);
    check_output("add_in2", alu_in2, 32'd7);
    check_output("add_opcode", 32'(alu_opcode), 32'd0);
    check_output("add_rd", 32'(alu_rd), 32'd3);
    tick();
    check_output("add_drain_valid", 32'(alu_valid), 32'd0);

    for (int k = 0; k < 6; k++) begin
      apply_stimulus(mk(vecs[k].op, vecs[k].rd, vecs[k].s, vecs[k].rn, vecs[k].rm,
                        vecs[k].sc, vecs[k].sa, vecs[k].i, vecs[k].imm), 1'b1);
      #1;
      check_output($sformatf("v%0d_ready", k), 32'(instr_ready), 32'd1);
      tick();
      apply_stimulus('0, 1'b0);
      check_output($sformatf("v%0d_valid", k), 32'(alu_valid), 32'd1);
      check_output($sformatf("v%0d_in1", k), alu_in1, vecs[k].exp_in1);
      check_output($sformatf("v%0d_in2", k), alu_in2, vecs[k].exp_in2);
      check_output($sformatf("v%0d_opcode", k), 32'(alu_opcode), 32'(vecs[k].op));
      check_output($sformatf("v%0d_rd", k), 32'(alu_rd), 32'(vecs[k].rd));
      check_output($sformatf("v%0d_sr_cont", k), 32'(alu_sr_cont), 32'(vecs[k].sc));
      check_output($sformatf("v%0d_sr_bit", k), 32'(alu_sr_bit), 32'(vecs[k].sa));
      check_output($sformatf("v%0d_set_flags", k), 32'(alu_set_flags), 32'(vecs[k].s));
    end
    tick();
    check_output("table_drain_valid", 32'(alu_valid), 32'd0);

    // Illegal opcode: consumed, pulses once, no bundle and no pending change.
    apply_stimulus(mk(4'b1010, 4'd14, 1'b0, 4'd1, 4'd2, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("illegal_ready", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus('0, 1'b0);
    check_output("illegal_pulse", 32'(illegal_instr), 32'd1);
    check_output("illegal_valid", 32'(alu_valid), 32'd0);
    tick();
    check_output("illegal_pulse_end", 32'(illegal_instr), 32'd0);
    apply_stimulus(mk(4'd1, 4'd15, 1'b0, 4'd3, 4'd1, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("illegal_r3_still_pending", 32'(instr_ready), 32'd0);
    apply_stimulus(mk(4'd0, 4'd14, 1'b0, 4'd1, 4'd2, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("illegal_r14_not_pending", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus('0, 1'b0);
    tick();

    // SUB r4,r3,r1 waits on r3 until its writeback of 12 arrives two cycles later.
    apply_stimulus(mk(4'd1, 4'd4, 1'b0, 4'd3, 4'd1, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("raw_stall_c0", 32'(instr_ready), 32'd0);
    tick();
    check_output("raw_stall_c1", 32'(instr_ready), 32'd0);
    tick();
    wb_en   = 1'b1;
    wb_addr = 4'd3;
    wb_data = 32'd12;
    #1;
    waited = 0;
    while (!instr_ready && waited < 4) begin
      tick();
      wb_en = 1'b0;
      waited++;
    end
    check_output("raw_wait_cycles", 32'(waited), 32'(exp_wait));
    tick();
    wb_en = 1'b0;
    apply_stimulus('0, 1'b0);
    check_output("raw_valid", 32'(alu_valid), 32'd1);
    check_output("raw_in1", alu_in1, 32'd12);
    check_output("raw_in2", alu_in2, 32'd5);
    check_output("raw_rd", 32'(alu_rd), 32'd4);
    tick();

    // Back-pressure: bundle must hold while alu_ready=0, then transfer with no bubble.
    alu_ready = 1'b0;
    apply_stimulus(mk(4'd0, 4'd1, 1'b0, 4'd2, 4'd7, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("bp_first_ready", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus(mk(4'd1, 4'd6, 1'b0, 4'd7, 4'd2, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("bp_c%0d_ready", c), 32'(instr_ready), 32'd0);
      check_output($sformatf("bp_c%0d_valid", c), 32'(alu_valid), 32'd1);
      check_output($sformatf("bp_c%0d_in1", c), alu_in1, 32'd7);
      check_output($sformatf("bp_c%0d_in2", c), alu_in2, 32'd3);
      tick();
    end
    alu_ready = 1'b1;
    #1;
    check_output("bp_release_ready", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus('0, 1'b0);
    check_output("bp_b2b_valid", 32'(alu_valid), 32'd1);
    check_output("bp_b2b_in1", alu_in1, 32'd3);
    check_output("bp_b2b_in2", alu_in2, 32'd7);
    check_output("bp_b2b_opcode", 32'(alu_opcode), 32'd1);
    check_output("bp_b2b_rd", 32'(alu_rd), 32'd6);
    tick();

    // Reset while a bundle is held and r5 is pending.
    alu_ready = 1'b0;
    apply_stimulus(mk(4'd0, 4'd5, 1'b1, 4'd0, 4'd2, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    tick();
    apply_stimulus('0, 1'b0);
    check_output("mid_valid", 32'(alu_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_reset_valid", 32'(alu_valid), 32'd0);
    check_output("mid_reset_in2", alu_in2, 32'd0);
    check_output("mid_reset_rd", 32'(alu_rd), 32'd0);
    check_output("mid_reset_flags", 32'(alu_set_flags), 32'd0);
    check_output("mid_reset_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    alu_ready = 1'b1;
    apply_stimulus(mk(4'd0, 4'd9, 1'b0, 4'd5, 4'd5, 3'd0, 5'd0, 1'b0, 6'h00), 1'b1);
    #1;
    check_output("post_reset_ready", 32'(instr_ready), 32'd1);
    tick();
    apply_stimulus('0, 1'b0);
    check_output("post_reset_valid", 32'(alu_valid), 32'd1);
    check_output("post_reset_in1", alu_in1, 32'd0);
    check_output("post_reset_rd", 32'(alu_rd), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREGS, default 16, register-file depth; the register index width is fixed at 4 bits.
REQ-002 SHALL have parameter IMM_W, default 10, immediate-operand width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port instr_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port instr  input  32  instruction word.
REQ-007 SHALL have port instr_ready  output  1  instruction accepted when high together with instr_valid.
REQ-008 SHALL have ports wb_en, wb_addr[3:0], wb_data[31:0]  input  writeback port from the downstream stage.
REQ-009 SHALL have port alu_valid  output  1  issue bundle valid.
REQ-010 SHALL have port alu_ready  input  1  ALU stage can take the bundle.
REQ-011 SHALL have ports alu_in1[31:0], alu_in2[31:0], alu_opcode[3:0], alu_sr_cont[2:0], alu_sr_bit[4:0], alu_rd[3:0], alu_set_flags  output  the registered issue bundle.
REQ-012 SHALL have port illegal_instr  output  1  one-cycle pulse when an accepted opcode is greater than 4'b0101.

Function
REQ-013 SHALL decode instr as: [31:28] opcode, [27:24] rd, [23] S, [22:19] rn, [18:15] rm, [14:12] shift control, [11:7] shift amount, [6] I, [5:0] immediate low bits.
REQ-014 SHALL drive alu_in2 from regfile[rm] when I=0, and from zero-extended {instr[18:15], instr[5:0]} when I=1; shift fields pass through unchanged in both cases.
REQ-015 SHALL drive alu_in1 from regfile[rn].
REQ-016 SHALL hold a 1-bit pending flag per register, set when an instruction targeting rd issues and cleared on wb_en for wb_addr.
REQ-017 SHALL give set priority over clear when an issue and a writeback target the same register in the same cycle.
REQ-018 SHALL stall (instr_ready=0) when pending[rn], pending[rd], or, for I=0, pending[rm] is set, except where REQ-026 permits forwarding.
REQ-019 SHALL assert instr_ready = !hazard && (!alu_valid || alu_ready).
REQ-020 SHALL load the bundle register one cycle after acceptance (latency 1), and hold the bundle stable while alu_valid=1 and alu_ready=0.
REQ-021 SHALL clear alu_valid on an alu_ready handshake when no new instruction is accepted in the same cycle; acceptance and drain in the same cycle gives back-to-back issue.
REQ-022 SHALL consume an illegal opcode (instr_ready follows REQ-019), pulse illegal_instr, and leave alu_valid and the pending flags unchanged.
REQ-023 SHALL write wb_data to regfile[wb_addr] on the clock edge when wb_en=1.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear every regfile entry, every pending flag, alu_valid, illegal_instr and all bundle outputs to 0; instr_ready is 0 during reset.
REQ-025 SHALL discard any in-flight bundle when reset asserts mid-operation; the first accept after reset release can occur on the first rising edge.

Configuration
REQ-026 SHALL, with ALU_ISSUE_FWD_EN defined, forward wb_data to a source operand whose index equals wb_addr while wb_en=1, and treat that source as non-pending for REQ-018 in that cycle.
REQ-027 SHALL, without ALU_ISSUE_FWD_EN, read only the register file and stall through the writeback cycle, so the dependent instruction is accepted one cycle later.

Structure
REQ-028 SHALL take the opcode encodings (ADD=0 ... XOR=5), shift-control encodings and instruction field positions from the shared package alu_pkg.
REQ-029 SHALL contain exactly one sub-module: alu_scoreboard (pending flags, hazard detection, set/clear priority).

Verification
REQ-030 SHALL show: after reset, wb r1=5 and r2=7, then issue ADD r3,r1,r2 (I=0) -> next cycle alu_valid=1, in1=5, in2=7, opcode=0, rd=3.
REQ-031 SHALL show: ADD r3 issues, then SUB r4,r3,r1 follows and wb r3=12 arrives two cycles later -> SUB is accepted in the wb cycle (FWD_EN) or one cycle after it (no FWD_EN), with in1=12 in both cases.
REQ-032 SHALL show: alu_ready held 0 for 3 cycles -> bundle stable, instr_ready=0; alu_ready=1 with a new instr_valid -> back-to-back transfer with no bubble.
REQ-033 SHALL show: opcode 4'b1010 accepted -> illegal_instr pulses once, alu_valid stays 0, pending flags unchanged.
REQ-034 SHALL show: I=1 with {rm=4'hA, low=6'h3F} -> in2=32'h0000_02BF; shift control 3'b001 and amount 4 appear unchanged on alu_sr_cont and alu_sr_bit.
REQ-035 SHALL show: rst_n dropped while alu_valid=1 and r5 pending -> all outputs 0 immediately and pending cleared, and an instruction reading r5 is accepted at the first edge after release.
